// File: rtl/scan_drv_pkg.sv
// Shared state encodings and decode helpers for the scan chain driver.
package scan_drv_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SHIFT   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_UNLOAD  = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        StIdle    = ST_IDLE,
        StShift   = ST_SHIFT,
        StCapture = ST_CAPTURE,
        StUnload  = ST_UNLOAD,
        StDone    = ST_DONE
    } scan_drv_state_t;

    // States in which the chain is in shift mode (SE high).
    function automatic logic is_scan_state(input scan_drv_state_t s);
        return (s == StShift) || (s == StUnload);
    endfunction

    function automatic logic is_busy_state(input scan_drv_state_t s);
        return (s == StShift) || (s == StCapture) || (s == StUnload);
    endfunction

endpackage

// File: rtl/scan_drv_shreg.sv
// Parallel-load, MSB-first shift register; serial data enters at the LSB.
module scan_drv_shreg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] par_o,
    output logic             ser_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Load wins over shift so a clear can cancel a shift in progress.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_val_i;
        end else if (shift_i) begin
            data_d = {data_q[WIDTH-2:0], ser_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign par_o = data_q;
    assign ser_o = data_q[WIDTH-1];

endmodule

// File: rtl/scan_chain_driver.sv
// Scan-test initiator: shift in a pattern, pulse one capture cycle, shift out the response.
// Optional compare logic is enabled with `define SCAN_CHAIN_DRIVER_CMP_EN.
module scan_chain_driver
    import scan_drv_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 16,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] load_data,
    input  logic                 SO,
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
    input  logic [CHAIN_LEN-1:0] exp_data,
    input  logic [CHAIN_LEN-1:0] cmp_mask,
    output logic [CHAIN_LEN-1:0] fail_bits,
    output logic                 mismatch,
`endif
    output logic                 SE,
    output logic                 SI,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] unload_data
);

    scan_drv_state_t      state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 se_q, se_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [CHAIN_LEN-1:0] unload_q, unload_d;

    logic                 accept;
    logic                 cancel;
    logic                 last_cnt;
    logic                 finish;
    logic [CHAIN_LEN-1:0] ld_par;
    logic [CHAIN_LEN-1:0] unl_par;
    logic                 unl_ser;
    logic [CHAIN_LEN-1:0] unload_word;

    assign accept   = (state_q == StIdle) && start && !abort;
    assign cancel   = (state_q != StIdle) && abort;
    assign last_cnt = (cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign finish   = (state_q == StUnload) && (state_d == StDone);

    // The final SO bit is folded in combinationally so the full word is ready with done.
    assign unload_word = {unl_par[CHAIN_LEN-2:0], SO};

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    if (start) state_d = StShift;
                StShift:   if (last_cnt) state_d = StCapture;
                StCapture: state_d = StUnload;
                StUnload:  if (last_cnt) state_d = StDone;
                StDone:    state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && is_scan_state(state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        se_d     = is_scan_state(state_d);
        busy_d   = is_busy_state(state_d);
        done_d   = (state_d == StDone);
        unload_d = finish ? unload_word : unload_q;
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            se_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            unload_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            se_q     <= se_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            unload_q <= unload_d;
        end
    end

    // Pattern register drains to zero after N shifts, so SI is 0 outside SHIFT;
    // an abort clears it to keep SI low in IDLE.
    scan_drv_shreg #(
        .WIDTH (CHAIN_LEN)
    ) u_load_shreg (
        .clk_i      (CLK),
        .rst_ni     (RSTB),
        .load_i     (accept || cancel),
        .load_val_i (accept ? load_data : '0),
        .shift_i    (state_q == StShift),
        .ser_i      (1'b0),
        .par_o      (ld_par),
        .ser_o      (SI)
    );

    scan_drv_shreg #(
        .WIDTH (CHAIN_LEN)
    ) u_unload_shreg (
        .clk_i      (CLK),
        .rst_ni     (RSTB),
        .load_i     (accept),
        .load_val_i ('0),
        .shift_i    (state_q == StUnload),
        .ser_i      (SO),
        .par_o      (unl_par),
        .ser_o      (unl_ser)
    );

    logic unused_bits;
    assign unused_bits = ^{ld_par, unl_par[CHAIN_LEN-1], unl_ser};

`ifdef SCAN_CHAIN_DRIVER_CMP_EN
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic [CHAIN_LEN-1:0] mask_q, mask_d;
    logic [CHAIN_LEN-1:0] fail_q, fail_d;
    logic                 mismatch_q, mismatch_d;

    always_comb begin
        exp_d      = accept ? exp_data : exp_q;
        mask_d     = accept ? cmp_mask : mask_q;
        fail_d     = finish ? ((unload_word ^ exp_q) & mask_q) : fail_q;
        mismatch_d = |fail_d;
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            exp_q      <= '0;
            mask_q     <= '0;
            fail_q     <= '0;
            mismatch_q <= 1'b0;
        end else begin
            exp_q      <= exp_d;
            mask_q     <= mask_d;
            fail_q     <= fail_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign fail_bits = fail_q;
    assign mismatch  = mismatch_q;
`endif

    assign SE          = se_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign unload_data = unload_q;

endmodule

// File: tb/tb_scan_chain_driver.sv
// Randomized bench for scan_chain_driver driving a 4-flop behavioural scan chain.
module tb_scan_chain_driver;

    localparam int N = 4;

    logic         CLK;
    logic         RSTB;
    logic         start;
    logic         abort;
    logic [N-1:0] load_data;
    logic         SO;
    logic         SE;
    logic         SI;
    logic         busy;
    logic         done;
    logic [N-1:0] unload_data;
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
    logic [N-1:0] exp_data;
    logic [N-1:0] cmp_mask;
    logic [N-1:0] fail_bits;
    logic         mismatch;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: last completed response and compare result.
    logic [N-1:0] model_unl;
    logic [N-1:0] model_fail;

    // Behavioural chain; functional D is either each flop's own Q or a forced word.
    logic         func_loop;
    logic [N-1:0] func_val;
    logic [N-1:0] chain_q;

    always_ff @(posedge CLK) begin
        if (SE) chain_q <= {chain_q[N-2:0], SI};
        else    chain_q <= func_loop ? chain_q : func_val;
    end
    assign SO = chain_q[N-1];

    scan_chain_driver #(
        .CHAIN_LEN (N)
    ) dut (
        .CLK         (CLK),
        .RSTB        (RSTB),
        .start       (start),
        .abort       (abort),
        .load_data   (load_data),
        .SO          (SO),
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
        .exp_data    (exp_data),
        .cmp_mask    (cmp_mask),
        .fail_bits   (fail_bits),
        .mismatch    (mismatch),
`endif
        .SE          (SE),
        .SI          (SI),
        .busy        (busy),
        .done        (done),
        .unload_data (unload_data)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_cmp_held();
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
        check_eq("fail_bits_hold", fail_bits, model_fail);
        check_eq("mismatch_hold", mismatch, |model_fail);
`endif
    endtask

    // Start sampled at edge 0; cycle c lies between edge c-1 and edge c.
    task automatic run_op(input logic [N-1:0] ld, input bit loop, input logic [N-1:0] fv,
                          input logic [N-1:0] ex, input logic [N-1:0] mk,
                          input int abort_cyc, input int stray_cyc);
        logic [N-1:0] exp_unl;
        logic         exp_si;
        exp_unl   = loop ? ld : fv;
        func_loop = loop;
        func_val  = fv;
        load_data = ld;
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
        exp_data  = ex;
        cmp_mask  = mk;
`endif
        start = 1'b1;
        @(negedge CLK);
        start     = 1'b0;
        load_data = N'($urandom);
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
        exp_data  = N'($urandom);
        cmp_mask  = N'($urandom);
`endif
        for (int c = 1; c <= 2 * N + 2; c++) begin
            exp_si = 1'b0;
            if (c <= N) exp_si = ld[N-c];
            check_eq("se", SE, (c <= N) || (c >= N + 2 && c <= 2 * N + 1));
            check_eq("si", SI, exp_si);
            check_eq("busy", busy, c <= 2 * N + 1);
            check_eq("done", done, c == 2 * N + 2);
            if (c == 2 * N + 2) begin
                model_unl = exp_unl;
                check_eq("unload", unload_data, model_unl);
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
                model_fail = (exp_unl ^ ex) & mk;
                check_eq("fail_bits", fail_bits, model_fail);
                check_eq("mismatch", mismatch, |model_fail);
`endif
            end else begin
                check_eq("unload_hold", unload_data, model_unl);
                check_cmp_held();
            end
            start = (c == stray_cyc);
            if (c == abort_cyc) begin
                abort = 1'b1;
                @(negedge CLK);
                abort = 1'b0;
                start = 1'b0;
                check_eq("abort_se", SE, 1'b0);
                check_eq("abort_si", SI, 1'b0);
                check_eq("abort_busy", busy, 1'b0);
                check_eq("abort_done", done, 1'b0);
                check_eq("abort_unload", unload_data, model_unl);
                check_cmp_held();
                @(negedge CLK);
                check_eq("abort_done2", done, 1'b0);
                check_eq("abort_busy2", busy, 1'b0);
                return;
            end
            @(negedge CLK);
        end
        // A start pulsed in the DONE cycle must not launch another operation.
        check_eq("post_done", done, 1'b0);
        check_eq("post_busy", busy, 1'b0);
        check_eq("post_se", SE, 1'b0);
        start = 1'b0;
    endtask

    initial begin
        RSTB       = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        load_data  = '0;
        func_loop  = 1'b1;
        func_val   = '0;
        model_unl  = '0;
        model_fail = '0;
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
        exp_data   = '0;
        cmp_mask   = '0;
`endif
        #12;
        check_eq("rst_se", SE, 1'b0);
        check_eq("rst_si", SI, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_unload", unload_data, '0);
        check_cmp_held();
        @(negedge CLK);
        RSTB = 1'b1;
        @(negedge CLK);

        // Loopback, forced capture, stray start, abort in second UNLOAD cycle.
        run_op(4'b1011, 1'b1, 4'b0000, 4'b0000, 4'b0000, -1, -1);
        run_op(4'b1001, 1'b0, 4'b0110, 4'b0110, 4'b1111, -1, -1);
        run_op(4'b0101, 1'b1, 4'b0000, 4'b1111, 4'b0011, -1, 3);
        run_op(4'b1110, 1'b0, 4'b0001, 4'b0000, 4'b1111, N + 3, -1);
        run_op(4'b0011, 1'b1, 4'b0000, 4'b0000, 4'b0000, -1, 2 * N + 2);

        // Reset asserted mid-SHIFT clears outputs immediately.
        load_data = 4'b1111;
        func_loop = 1'b1;
        start     = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        #2 RSTB = 1'b0;
        #1;
        check_eq("mid_rst_se", SE, 1'b0);
        check_eq("mid_rst_si", SI, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_done", done, 1'b0);
        check_eq("mid_rst_unload", unload_data, '0);
        model_unl  = '0;
        model_fail = '0;
        check_cmp_held();
        @(negedge CLK);
        RSTB = 1'b1;
        @(negedge CLK);
        run_op(4'b1100, 1'b1, 4'b0000, 4'b0000, 4'b0000, -1, -1);

        // Compare scenario: captured 0100 against expected 0110 -> fail bit 1.
        run_op(4'b1010, 1'b0, 4'b0100, 4'b0110, 4'b1111, -1, -1);
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
        check_eq("cmp_fail_bits", fail_bits, 4'b0010);
        check_eq("cmp_mismatch", mismatch, 1'b1);
`endif

        for (int i = 0; i < 40; i++) begin
            int ab;
            int st;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * N + 1)) : -1;
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * N + 2)) : -1;
            run_op(N'($urandom), 1'($urandom), N'($urandom), N'($urandom), N'($urandom), ab, st);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "timeout");
    end

endmodule
